uart_prog_loader: RTL and testbench

- Synthesizable program writer for the multicycle MIPS unified RAM; replaces testbench hierarchical preloading on the board.
- Receives a framed byte stream on a UART RX pin (8N1) and assembles big-endian 32-bit words.
- Writes the words into the RAM write port from word address 0 upward.
- Holds the CPU in reset until a load completes and its checksum passes.

---
 rtl/uart_prog_loader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Loads a program image into the multicycle MIPS unified RAM over a UART
//   RX line (8N1) and holds the CPU in reset until the load completes.
//
//   Frame: SYNC_BYTE, N (word count, 1..2**ADDR_W), 4*N data bytes
//   (big-endian words), and, when LOADER_CHECKSUM_EN is defined, one
//   trailing checksum byte equal to the XOR of all data bytes.
//
//   Optional feature macro: LOADER_CHECKSUM_EN (checksum byte + CHECK state).
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset (0 = reset)
//   rx            UART serial input, idles high
//   mem_we        one-cycle RAM write strobe
//   mem_addr      RAM word address
//   mem_wdata     RAM write data
//   cpu_hold      MIPS reset drive, 1 = CPU held
//   done          last load completed successfully
//   error         last load aborted
//   words_loaded  words written in the current or last load
module uart_prog_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         ADDR_W       = 7,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int WL_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WL_W-1:0]  WL_ONE    = WL_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [31:0]      MAX_WORDS = 32'd1 << ADDR_W;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state, rx_state_n;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             byte_valid, byte_valid_n;
    logic             frame_err, frame_err_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // rx_shift stays stable between bytes, so it doubles as the received
    // byte while byte_valid is high.
    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt + CNT_ONE;
        rx_bit_n     = rx_bit;
        rx_shift_n   = rx_shift;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                // Re-check the start bit at mid-bit; high means a glitch.
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_M1) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_M1) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERR
    } state_t;

    state_t          state, state_n;
    logic [WL_W-1:0] n_words;
    logic [1:0]      byte_idx;
    logic [23:0]     word_sr;
    logic [31:0]     count_ext;
    logic            count_ok;
    logic            is_sync;
    logic            last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      xor_acc;
`endif

    assign count_ext = {24'd0, rx_shift};
    assign count_ok  = (count_ext != 32'd0) && (count_ext <= MAX_WORDS);
    assign is_sync   = byte_valid && (rx_shift == SYNC_BYTE);
    assign last_word = ((words_loaded + WL_ONE) == n_words);

    assign done  = (state == DONE);
    assign error = (state == ERR);

    always_comb begin
        state_n = state;
        if (frame_err) begin
            state_n = ERR;
        end else begin
            case (state)
                IDLE:  if (is_sync) state_n = COUNT;
                COUNT: if (byte_valid) state_n = count_ok ? DATA : ERR;
                DATA: begin
                    // Leave DATA in the cycle after the final write strobe.
                    if (mem_we && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_n = CHECK;
`else
                        state_n = DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (byte_valid) state_n = (rx_shift == xor_acc) ? DONE : ERR;
`endif
                DONE:  if (is_sync) state_n = COUNT;
                ERR:   if (is_sync) state_n = COUNT;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            n_words      <= '0;
            byte_idx     <= '0;
            word_sr      <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            // Release only once DONE has been held for a cycle; any exit
            // from DONE re-asserts hold on the same edge as the state change.
            cpu_hold <= !((state == DONE) && (state_n == DONE));
            case (state)
                COUNT: begin
                    if (byte_valid && count_ok) begin
                        n_words      <= count_ext[WL_W-1:0];
                        words_loaded <= '0;
                        mem_addr     <= '0;
                        byte_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc      <= '0;
`endif
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        word_sr  <= {word_sr[15:0], rx_shift};
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        xor_acc  <= xor_acc ^ rx_shift;
`endif
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {word_sr, rx_shift};
                        end
                    end
                    // Address holds on the final word so it never wraps.
                    if (mem_we) begin
                        words_loaded <= words_loaded + WL_ONE;
                        if (!last_word) begin
                            mem_addr <= mem_addr + ADDR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

    localparam int         CPB  = 4;
    localparam int         AW   = 7;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_DATA  = 2;
    localparam int M_CHECK = 3;
    localparam int M_DONE  = 4;
    localparam int M_ERR   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [AW+31:0] exp_q[$];   // {addr, data} of each expected write
    logic [7:0]     frame_q[$];
    logic [31:0]    wq[$];

    // Reference model: frame-level parse of the byte stream.
    int         m_st;
    int         m_n;
    int         m_w;
    logic [7:0] m_x;
    logic [7:0] m_bytes[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic model_reset();
        m_st = M_IDLE;
        m_n  = 0;
        m_w  = 0;
        m_x  = 8'h00;
        m_bytes.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_st = M_ERR;
            m_bytes.delete();
            return;
        end
        case (m_st)
            M_IDLE, M_DONE, M_ERR: if (b == SYNC) m_st = M_COUNT;
            M_COUNT: begin
                if (b == 8'd0 || int'(b) > (1 << AW)) begin
                    m_st = M_ERR;
                end else begin
                    m_n = int'(b);
                    m_w = 0;
                    m_x = 8'h00;
                    m_bytes.delete();
                    m_st = M_DATA;
                end
            end
            M_DATA: begin
                m_bytes.push_back(b);
                m_x = m_x ^ b;
                if (m_bytes.size() == 4) begin
                    exp_q.push_back({AW'(m_w), m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]});
                    m_w++;
                    m_bytes.delete();
                    if (m_w == m_n) m_st = CHECK_EN ? M_CHECK : M_DONE;
                end
            end
            M_CHECK: m_st = (b == m_x) ? M_DONE : M_ERR;
            default: ;
        endcase
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        model_byte(b, bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(!bad);
        if (bad) begin
            rx = 1'b1;
            repeat (3 * CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
    endtask

    task automatic build_frame(input bit corrupt);
        logic [7:0] x;
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(SYNC);
        frame_q.push_back(8'(wq.size()));
        foreach (wq[i]) begin
            for (int k = 3; k >= 0; k--) begin
                logic [7:0] bb;
                bb = wq[i][8*k +: 8];
                frame_q.push_back(bb);
                x = x ^ bb;
            end
        end
        if (CHECK_EN) frame_q.push_back(x ^ {7'd0, corrupt});
    endtask

    task automatic check_status(input string name);
        check({name, "_done"}, done, m_st == M_DONE);
        check({name, "_error"}, error, m_st == M_ERR);
        check({name, "_cpu_hold"}, cpu_hold, m_st != M_DONE);
        check({name, "_words_loaded"}, words_loaded, 64'(m_w));
        check({name, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    initial begin
        logic [AW+31:0] e;
        forever begin
            @(negedge clk);
            if (rst && mem_we) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: addr %0d data %h, no write expected", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr_data", {mem_addr, mem_wdata}, e);
                end
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check_status("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Glitch on idle line produces no byte
        glitch();
        check_status("idle_glitch");

        // Reference 2-word load
        wq = {32'h8C08003F, 32'h20090001};
        build_frame(1'b0);
        send_frame();
        check_status("plan_frame");
        check("plan_done_const", done, 1);
        check("plan_words_const", words_loaded, 2);

        if (CHECK_EN) begin
            build_frame(1'b1);
            send_frame();
            check_status("bad_checksum");
            build_frame(1'b0);
            send_frame();
            check_status("after_bad_checksum");
        end

        // Count bounds
        frame_q = {SYNC, 8'h00};
        send_frame();
        check_status("count_zero");
        frame_q = {SYNC, 8'h81};
        send_frame();
        check_status("count_81");
        wq.delete();
        for (int i = 0; i < 128; i++) wq.push_back($urandom());
        build_frame(1'b0);
        send_frame();
        check_status("count_128");

        // Garbage before sync
        frame_q = {8'h00, 8'hFF, 8'h3C};
        send_frame();
        wq = {32'hA5A5A5A5, 32'h000000A5};
        build_frame(1'b0);
        send_frame();
        check_status("garbage_then_frame");

        // Framing error on the 3rd data byte
        frame_q = {SYNC, 8'h02, 8'h12, 8'h34};
        send_frame();
        send_byte(8'h56, 1'b1);
        check_status("framing_error");
        glitch();
        check_status("err_glitch");

        // Reset after 5 data bytes
        frame_q = {SYNC, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame();
        check("midload_pending", exp_q.size(), 0);
        rst = 1'b0;
        #1;
        check("midload_reset_we", mem_we, 0);
        check("midload_reset_addr", mem_addr, 0);
        check("midload_reset_wdata", mem_wdata, 0);
        check("midload_reset_hold", cpu_hold, 1);
        check("midload_reset_words", words_loaded, 0);
        model_reset();
        check_status("midload_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wq = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        build_frame(1'b0);
        send_frame();
        check_status("after_midload_reset");

        // Randomized frames
        for (int it = 0; it < 8; it++) begin
            int ng;
            ng = $urandom_range(0, 2);
            frame_q.delete();
            for (int g = 0; g < ng; g++) begin
                logic [7:0] gb;
                gb = 8'($urandom());
                if (gb == SYNC) gb = 8'h5A;
                frame_q.push_back(gb);
            end
            if (ng > 0) send_frame();
            wq.delete();
            for (int w = 0; w < $urandom_range(1, 4); w++) wq.push_back($urandom());
            build_frame($urandom_range(0, 3) == 0);
            send_frame();
            check_status($sformatf("random_%0d", it));
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
